// File: rtl/mux_4x1_from_2x1_if.sv
// Bus interface for the registered 4:1 lane selector.
// Groups the packed input lanes, the select, and the valid qualifier with the
// registered result. The master drives lanes, select and valid. The slave
// returns the selected lane and its valid flag.
interface mux_4x1_from_2x1_if #(
    parameter int DATA_W = 1
);
    logic [4*DATA_W-1:0] in;
    logic [1:0]          sel;
    logic                in_valid;
    logic [DATA_W-1:0]   out;
    logic                out_valid;

    modport master (
        output in, sel, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  in, sel, in_valid,
        output out, out_valid
    );
endinterface

// File: rtl/mux_4x1_from_2x1.sv
// Registered 4:1 multiplexer built as a two-level tree of 2:1 mux cells.
// Lane k is bus.in[k*DATA_W +: DATA_W]. With sel = k, out shows lane k one
// clock later. out_valid is a one-cycle-delayed copy of in_valid.
// Optional build macro MUX4_COMB_OUT_EN adds the out_comb port. That port
// gives the unregistered tree output with zero latency and ignores rst.

// Generic 2:1 selector used at every node of the tree.
module mux2_cell #(
    parameter int DATA_W = 1
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module mux_4x1_from_2x1 #(
    parameter int DATA_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    mux_4x1_from_2x1_if.slave  bus
`ifdef MUX4_COMB_OUT_EN
    ,
    output logic [DATA_W-1:0]  out_comb
`endif
);
    logic [DATA_W-1:0] lane [4];
    logic [DATA_W-1:0] m0;
    logic [DATA_W-1:0] m1;
    logic [DATA_W-1:0] y;

    // Unpack the flat input bus into four lanes.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane[k] = bus.in[k*DATA_W +: DATA_W];
    end

    // Level 1: sel[0] chooses inside each lane pair.
    mux2_cell #(.DATA_W(DATA_W)) u_l1a (
        .sel (bus.sel[0]),
        .a   (lane[0]),
        .b   (lane[1]),
        .y   (m0)
    );

    mux2_cell #(.DATA_W(DATA_W)) u_l1b (
        .sel (bus.sel[0]),
        .a   (lane[2]),
        .b   (lane[3]),
        .y   (m1)
    );

    // Level 2: sel[1] chooses between the two pairs.
    mux2_cell #(.DATA_W(DATA_W)) u_l2 (
        .sel (bus.sel[1]),
        .a   (m0),
        .b   (m1),
        .y   (y)
    );

`ifdef MUX4_COMB_OUT_EN
    assign out_comb = y;
`endif

    // Output register: capture the tree result every cycle. Reset has priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out       <= y;
            bus.out_valid <= bus.in_valid;
        end
    end
endmodule

// File: tb/tb_mux_4x1_from_2x1.sv
// Self-checking bench for mux_4x1_from_2x1. It drives a 1-bit-lane instance
// and an 8-bit-lane instance in lockstep. Expected results are queued when
// stimulus is applied, then popped and compared just after the capturing edge.
`timescale 1ns/1ps
module tb_mux_4x1_from_2x1;
    localparam logic [31:0] WIDE = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_4x1_from_2x1_if #(.DATA_W(1)) bus1 ();
    mux_4x1_from_2x1_if #(.DATA_W(8)) bus8 ();

`ifdef MUX4_COMB_OUT_EN
    logic       comb1;
    logic [7:0] comb8;
`endif

    mux_4x1_from_2x1 #(.DATA_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
`ifdef MUX4_COMB_OUT_EN
        , .out_comb (comb1)
`endif
    );

    mux_4x1_from_2x1 #(.DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
`ifdef MUX4_COMB_OUT_EN
        , .out_comb (comb8)
`endif
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  sel;
        logic [3:0]  in1;
        logic [31:0] in8;
        logic        e1;
        logic [7:0]  e8;
        logic        ev;
    } vec_t;

    typedef struct {
        logic       e1;
        logic [7:0] e8;
        logic       ev;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue its expectation.
    // After the next rising edge, pop the expectation and compare.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst           = v.rst;
        bus1.in_valid = v.vld;
        bus8.in_valid = v.vld;
        bus1.sel      = v.sel;
        bus8.sel      = v.sel;
        bus1.in       = v.in1;
        bus8.in       = v.in8;
        sb.push_back('{e1: v.e1, e8: v.e8, ev: v.ev});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".out1"},  {31'd0, bus1.out},       {31'd0, e.e1});
            check({tag, ".out8"},  {24'd0, bus8.out},       {24'd0, e.e8});
            check({tag, ".valid"}, {31'd0, bus1.out_valid}, {31'd0, e.ev});
            check({tag, ".valid8"},{31'd0, bus8.out_valid}, {31'd0, e.ev});
        end
    endtask

    vec_t tbl[13];

    initial begin
        rst           = 1'b1;
        bus1.in       = '0;
        bus8.in       = '0;
        bus1.sel      = 2'd0;
        bus8.sel      = 2'd0;
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;

        // Reset held two cycles with all-ones lanes and sel=3, then release.
        tbl[0]  = '{1'b1, 1'b1, 2'd3, 4'b1111, WIDE, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd3, 4'b1111, WIDE, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd3, 4'b1111, WIDE, 1'b1, 8'hD4, 1'b1};
        // Pattern 1010 stepped through sel 0..3.
        tbl[3]  = '{1'b0, 1'b1, 2'd0, 4'b1010, WIDE, 1'b0, 8'hA1, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 4'b1010, WIDE, 1'b1, 8'hB2, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 2'd2, 4'b1010, WIDE, 1'b0, 8'hC3, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 2'd3, 4'b1010, WIDE, 1'b1, 8'hD4, 1'b1};
        // Inverse pattern 0101. The first row changes in and sel together.
        tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'b0101, WIDE, 1'b1, 8'hA1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 2'd1, 4'b0101, WIDE, 1'b0, 8'hB2, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 2'd2, 4'b0101, WIDE, 1'b1, 8'hC3, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 2'd3, 4'b0101, WIDE, 1'b0, 8'hD4, 1'b1};
        // Non-monotonic select order and swapped wide lanes.
        tbl[11] = '{1'b0, 1'b1, 2'd2, 4'b0100, 32'h0F1E2D3C, 1'b1, 8'h1E, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 4'b0010, 32'h0F1E2D3C, 1'b1, 8'h2D, 1'b1};

        for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // All-zero lanes held for ten cycles, then pattern 1010 on sel 0..3.
        for (int i = 0; i < 10; i++)
            step('{1'b0, 1'b1, 2'd0, 4'b0000, 32'h0, 1'b0, 8'h00, 1'b1}, "hold0");
        step('{1'b0, 1'b1, 2'd0, 4'b1010, WIDE, 1'b0, 8'hA1, 1'b1}, "sw0");
        step('{1'b0, 1'b1, 2'd1, 4'b1010, WIDE, 1'b1, 8'hB2, 1'b1}, "sw1");
        step('{1'b0, 1'b1, 2'd2, 4'b1010, WIDE, 1'b0, 8'hC3, 1'b1}, "sw2");
        step('{1'b0, 1'b1, 2'd3, 4'b1010, WIDE, 1'b1, 8'hD4, 1'b1}, "sw3");

        // A valid sample on sel=2 is discarded when reset arrives the next edge.
        step('{1'b0, 1'b1, 2'd2, 4'b0100, WIDE, 1'b1, 8'hC3, 1'b1}, "mid_pre");
        step('{1'b1, 1'b1, 2'd2, 4'b0100, WIDE, 1'b0, 8'h00, 1'b0}, "mid_rst");
        step('{1'b0, 1'b1, 2'd2, 4'b0100, WIDE, 1'b1, 8'hC3, 1'b1}, "mid_post");

        // With in_valid low, out still follows sel and out_valid stays low.
        step('{1'b0, 1'b0, 2'd3, 4'b1000, WIDE, 1'b1, 8'hD4, 1'b0}, "nv3");
        step('{1'b0, 1'b0, 2'd0, 4'b1000, WIDE, 1'b0, 8'hA1, 1'b0}, "nv0");
        step('{1'b0, 1'b0, 2'd1, 4'b0010, WIDE, 1'b1, 8'hB2, 1'b0}, "nv1");

`ifdef MUX4_COMB_OUT_EN
        // Change sel mid-cycle. out_comb follows at once, out only at the edge.
        @(negedge clk);
        rst      = 1'b0;
        bus1.in  = 4'b0010;
        bus8.in  = WIDE;
        bus1.sel = 2'd0;
        bus8.sel = 2'd0;
        #1;
        check("comb1.s0", {31'd0, comb1}, 32'd0);
        check("comb8.s0", {24'd0, comb8}, 32'hA1);
        check("reg8.hold", {24'd0, bus8.out}, 32'hB2);
        bus1.sel = 2'd1;
        bus8.sel = 2'd1;
        #1;
        check("comb1.s1", {31'd0, comb1}, 32'd1);
        check("comb8.s1", {24'd0, comb8}, 32'hB2);
        bus8.sel = 2'd3;
        #1;
        check("comb8.s3", {24'd0, comb8}, 32'hD4);
        check("reg8.still", {24'd0, bus8.out}, 32'hB2);
        @(posedge clk);
        #1;
        check("reg8.after", {24'd0, bus8.out}, 32'hD4);
        check("reg1.after", {31'd0, bus1.out}, 32'd1);
        // out_comb ignores reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("comb8.rst", {24'd0, comb8}, 32'hD4);
        @(posedge clk);
        #1;
        check("reg8.rst", {24'd0, bus8.out}, 32'h00);
        check("comb8.rst2", {24'd0, comb8}, 32'hD4);
`endif

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mux_4x1_from_2x1.md
Name: mux_4x1_from_2x1

Overview:
- Registered 4:1 multiplexer built as a two-level tree of three 2:1 mux cells.
- Selects one of four equal-width lanes packed in a single input bus, using a 2-bit select.
- Used as a leaf data selector in datapaths. Output is registered on the single system clock.

Parameters:
- DATA_W, 1, width in bits of each of the four input lanes and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in  input  4*DATA_W  packed lanes: lane k = in[k*DATA_W +: DATA_W], k=0..3.
- sel  input  2  lane select; value k selects lane k.
- in_valid  input  1  qualifies in/sel for capture.
- out  output  DATA_W  registered selected lane.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Mux tree structure, all combinational:
  - Level 1a: m0 = sel[0] ? lane1 : lane0.
  - Level 1b: m1 = sel[0] ? lane3 : lane2.
  - Level 2: y = sel[1] ? m1 : m0.
- The 2:1 cell is a separate submodule instantiated three times. It is parameterised by DATA_W.
- Functional mapping: sel=0 -> lane0, 1 -> lane1, 2 -> lane2, 3 -> lane3.
- Registering:
  - Every rising clk with rst=0: out <= y, out_valid <= in_valid.
  - Latency is exactly 1 cycle from in/sel change to out.
  - out updates every cycle regardless of in_valid. in_valid only flags meaningful data; no stall or backpressure.
- Reset:
  - rst=1 at a rising edge: out <= 0, out_valid <= 0.
  - rst has priority over the data path.
  - Reset asserted mid-stream discards the pending sample. The first sample after reset release appears one cycle after it is presented.
- Select changes every cycle are legal; each cycle's out reflects the previous cycle's sel and in.
- Simultaneous change of in and sel: out reflects the new in indexed by the new sel, one cycle later.
- X/Z on sel is not defined; the bench must drive a known sel.
- No internal state other than the out and out_valid registers.

Optional Feature:
- Macro MUX4_COMB_OUT_EN.
- Defined: adds output port out_comb (DATA_W). out_comb = y with zero latency, unaffected by rst.
- Undefined: port absent; only the registered out exists.
- The registered out behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with in=4'b1111, sel=3 -> out=0, out_valid=0. After rst drops, out=1 on the next edge.
- Sweep (DATA_W=1): in=4'b0000, sel=0, wait 10 cycles, then in=4'b1010. Step sel 0,1,2,3 one cycle each -> out = 0,1,0,1, each one cycle after its sel.
- Inverse pattern: in=4'b0101, sel 0..3 -> out = 1,0,1,0 one cycle later.
- Wide lanes (DATA_W=8): in={8'hD4,8'hC3,8'hB2,8'hA1}, sel 0..3 -> out = A1, B2, C3, D4.
- Valid and reset mid-stream: in_valid=1 with sel=2, assert rst on the next edge -> out=0, out_valid=0. in_valid=0 without reset -> out still follows sel, out_valid=0.
- MUX4_COMB_OUT_EN defined: change sel mid-cycle -> out_comb follows the same cycle, out one edge later.
